// File: rtl/ws_rpe_pkg.sv
// Shared types and default sizing for the eigenvector iteration datapath.
package ws_rpe_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      UPDATE,
      DONE,
      ERR
   } sched_state_t;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ITER_W     = 8;
   localparam int unsigned DEF_TIMEOUT    = 4096;

endpackage

// File: rtl/power_iter_sched.sv
// Power-iteration scheduler: restarts the matrix-vector engine with fed-back results
// until convergence, the iteration limit, or a watchdog timeout.
module power_iter_sched
   import ws_rpe_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ITER_W     = DEF_ITER_W,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  load_done,
   input  logic [ITER_W-1:0]     cfg_max_iter,
   input  logic [DATA_WIDTH-1:0] cfg_tol,
   output logic                  mv_start,
   output logic                  mv_src_fb,
   input  logic                  mv_done,
   input  logic [DATA_WIDTH-1:0] delta_in,
   output logic                  vec_wr_en,
   output logic                  result_valid,
   input  logic                  result_ack,
   output logic                  busy,
   output logic [ITER_W-1:0]     iter_count,
   output logic                  converged,
   output logic                  err_timeout,
   output logic                  load_ignored
);

   localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;

   sched_state_t          state_q, state_d;
   logic [WD_W-1:0]       wd_q, wd_d;
   logic [ITER_W-1:0]     max_q, max_d;
   logic [DATA_WIDTH-1:0] tol_q, tol_d;
   logic [ITER_W-1:0]     iter_q, iter_d, iter_inc;
   logic                  conv_q, conv_d;
   logic                  err_q, err_d;
   logic                  fb_q, fb_d;
   logic                  start_q, wr_q, rv_q, busy_q, ign_q;

   assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      max_d   = max_q;
      tol_d   = tol_q;
      iter_d  = iter_q;
      conv_d  = conv_q;
      err_d   = err_q;
      fb_d    = fb_q;
      unique case (state_q)
         IDLE: begin
            if (load_done) begin
               max_d   = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
               tol_d   = cfg_tol;
               iter_d  = '0;
               conv_d  = 1'b0;
               err_d   = 1'b0;
               fb_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // mv_done takes priority over a watchdog expiry in the same cycle
            if (mv_done) begin
               iter_d = iter_inc;
               if (delta_in <= tol_q) begin
                  conv_d  = 1'b1;
                  state_d = DONE;
               end else if (iter_inc >= max_q) begin
                  state_d = DONE;
               end else begin
                  state_d = UPDATE;
               end
            end else begin
               wd_d = wd_q + 1'b1;
               if (wd_q == WD_W'(TIMEOUT - 2)) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end
            end
         end
         UPDATE: begin
            fb_d    = 1'b1;
            state_d = START;
         end
         DONE: begin
            if (result_ack) state_d = IDLE;
         end
         ERR: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         wd_q    <= '0;
         max_q   <= '0;
         tol_q   <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
         err_q   <= 1'b0;
         fb_q    <= 1'b0;
         start_q <= 1'b0;
         wr_q    <= 1'b0;
         rv_q    <= 1'b0;
         busy_q  <= 1'b0;
         ign_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         max_q   <= max_d;
         tol_q   <= tol_d;
         iter_q  <= iter_d;
         conv_q  <= conv_d;
         err_q   <= err_d;
         fb_q    <= fb_d;
         // Strobes are registered from the next state so they align with the state itself
         start_q <= (state_d == START);
         wr_q    <= (state_d == UPDATE);
         rv_q    <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
         ign_q   <= load_done && (state_q != IDLE);
      end
   end

   assign mv_start     = start_q;
   assign mv_src_fb    = fb_q;
   assign vec_wr_en    = wr_q;
   assign result_valid = rv_q;
   assign busy         = busy_q;
   assign iter_count   = iter_q;
   assign converged    = conv_q;
   assign err_timeout  = err_q;
   assign load_ignored = ign_q;

endmodule

// File: tb/tb_power_iter_sched.sv
// Bench for power_iter_sched: acts as the engine and checks each job against a
// job-level model of passes and convergence.
module tb_power_iter_sched;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 8;
   localparam int unsigned TO = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          load_done = 1'b0;
   logic [IW-1:0] cfg_max_iter = '0;
   logic [DW-1:0] cfg_tol = '0;
   logic          mv_start, mv_src_fb, vec_wr_en, result_valid, busy;
   logic          converged, err_timeout, load_ignored;
   logic          mv_done = 1'b0;
   logic [DW-1:0] delta_in = '0;
   logic          result_ack = 1'b0;
   logic [IW-1:0] iter_count;

   int checks = 0;
   int errors = 0;
   int starts_cnt = 0;
   int wr_cnt = 0;
   int dseq [16];

   power_iter_sched #(
      .DATA_WIDTH (DW),
      .ITER_W     (IW),
      .TIMEOUT    (TO)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .load_done    (load_done),
      .cfg_max_iter (cfg_max_iter),
      .cfg_tol      (cfg_tol),
      .mv_start     (mv_start),
      .mv_src_fb    (mv_src_fb),
      .mv_done      (mv_done),
      .delta_in     (delta_in),
      .vec_wr_en    (vec_wr_en),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .busy         (busy),
      .iter_count   (iter_count),
      .converged    (converged),
      .err_timeout  (err_timeout),
      .load_ignored (load_ignored)
   );

   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      if (mv_start) starts_cnt++;
      if (vec_wr_en) wr_cnt++;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete job; the engine answers each mv_start after a random latency.
   task automatic run_job(input int mx, input int tol, input int hold, input bit inject,
                          input bit stray);
      int  eff, exp_n, s0, w0, lat;
      bit  exp_c, all_high;
      eff   = (mx == 0) ? 1 : mx;
      exp_n = 0;
      exp_c = 1'b0;
      for (int k = 0; k < 16; k++) begin
         exp_n = k + 1;
         if (dseq[k] <= tol) begin
            exp_c = 1'b1;
            break;
         end
         if (exp_n >= eff) break;
      end

      cfg_max_iter = IW'(mx);
      cfg_tol      = DW'(tol);
      load_done    = 1'b1;
      if (stray) begin
         mv_done  = 1'b1;
         delta_in = '0;
      end
      s0 = starts_cnt;
      w0 = wr_cnt;
      tick();
      load_done = 1'b0;
      mv_done   = 1'b0;
      chk("start_after_load", mv_start, 1);
      chk("busy_after_load", busy, 1);
      chk("iter_cleared", iter_count, 0);
      chk("err_cleared", err_timeout, 0);
      chk("no_ignore_on_accept", load_ignored, 0);

      for (int p = 0; p < exp_n; p++) begin
         chk("src_fb", mv_src_fb, (p > 0) ? 1 : 0);
         lat = $urandom_range(1, 5);
         if (inject && p == 0 && lat < 2) lat = 2;
         for (int i = 0; i < lat; i++) begin
            tick();
            if (inject && p == 0 && i == 0) begin
               load_done    = 1'b1;
               cfg_max_iter = IW'(1);
            end else if (inject && p == 0 && i == 1) begin
               load_done = 1'b0;
               chk("load_ignored_pulse", load_ignored, 1);
            end
         end
         mv_done  = 1'b1;
         delta_in = DW'(dseq[p]);
         tick();
         mv_done = 1'b0;
         chk("iter_count", iter_count, p + 1);
         if (p < exp_n - 1) begin
            chk("vec_wr_en", vec_wr_en, 1);
            chk("no_early_result", result_valid, 0);
            tick();
            chk("restart", mv_start, 1);
         end
      end

      chk("result_valid", result_valid, 1);
      chk("converged", converged, exp_c);
      all_high = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (result_valid !== 1'b1) all_high = 1'b0;
      end
      if (hold > 0) chk("result_held", all_high, 1);
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      chk("result_dropped", result_valid, 0);
      chk("idle_after_ack", busy, 0);
      chk("start_pulses", starts_cnt - s0, exp_n);
      chk("wr_pulses", wr_cnt - w0, exp_n - 1);
   endtask

   initial begin
      repeat (2) @(negedge aclk);
      chk("rst_busy", busy, 0);
      chk("rst_outputs", {mv_start, mv_src_fb, vec_wr_en, result_valid, converged,
                          err_timeout, load_ignored}, 0);
      chk("rst_iter", iter_count, 0);
      tick();
      aresetn = 1'b1;
      tick();

      // Iteration limit reached without convergence
      for (int k = 0; k < 16; k++) dseq[k] = 5;
      run_job(3, 0, 0, 1'b0, 1'b0);

      // Converges on the third pass
      dseq[0] = 20; dseq[1] = 9; dseq[2] = 8;
      run_job(10, 8, 0, 1'b0, 1'b0);

      // Zero limit behaves as one, with a long hold in DONE
      dseq[0] = 7;
      run_job(0, 0, 50, 1'b0, 1'b0);

      // Load arriving mid-job is dropped
      for (int k = 0; k < 16; k++) dseq[k] = 30 - k;
      run_job(4, 0, 0, 1'b1, 1'b0);

      // Watchdog expiry
      cfg_max_iter = IW'(5);
      cfg_tol      = '0;
      load_done    = 1'b1;
      tick();
      load_done = 1'b0;
      chk("to_start", mv_start, 1);
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 15) chk("to_err_before", err_timeout, 0);
         if (k == 16) begin
            chk("to_err_rise", err_timeout, 1);
            chk("to_busy_in_err", busy, 1);
         end
         if (k == 17) begin
            chk("to_idle", busy, 0);
            chk("to_err_sticky", err_timeout, 1);
            chk("to_no_result", result_valid, 0);
         end
      end
      for (int k = 0; k < 16; k++) dseq[k] = 0;
      run_job(2, 3, 0, 1'b0, 1'b0);

      // Reset during WAIT, then a clean job with a stray mv_done
      cfg_max_iter = IW'(5);
      load_done    = 1'b1;
      tick();
      load_done = 1'b0;
      tick();
      aresetn = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_outputs", {mv_start, mv_src_fb, vec_wr_en, result_valid}, 0);
      tick();
      aresetn = 1'b1;
      tick();
      for (int k = 0; k < 16; k++) dseq[k] = 12;
      run_job(2, 4, 0, 1'b0, 1'b1);

      // Randomised jobs
      for (int j = 0; j < 8; j++) begin
         for (int k = 0; k < 16; k++) dseq[k] = $urandom_range(0, 40);
         run_job($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
